// File: rtl/gb_apu_pkg.sv
// Game Boy APU frame sequencer: shared types, constants and the step schedule.
package gb_apu_pkg;

  localparam int FS_STEPS    = 8;
  localparam int FS_PRESCALE = 8192;

  typedef logic [2:0] fs_step_t;

  // Bit n set means step n fires that strobe.
  localparam logic [7:0] FS_LENGTH_MASK   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK    = 8'b0100_0100;
  localparam logic [7:0] FS_ENVELOPE_MASK = 8'b1000_0000;

  typedef struct packed {
    logic length;
    logic sweep;
    logic envelope;
  } fs_strobes_t;

  // Strobes produced when the given step executes.
  function automatic fs_strobes_t fs_schedule(fs_step_t s);
    fs_strobes_t r;
    r.length   = FS_LENGTH_MASK[s];
    r.sweep    = FS_SWEEP_MASK[s];
    r.envelope = FS_ENVELOPE_MASK[s];
    return r;
  endfunction

endpackage

// File: rtl/gb_apu_fs_tick_gen.sv
// Tick source for the frame sequencer.
// Build option GB_APU_FS_DIV_EDGE_EN: defined -> tick on DIV bit falling edge,
// undefined -> tick from an internal free-running prescaler.
module gb_apu_fs_tick_gen #(
  parameter int PRESCALE = 8192
) (
  input  logic clk,
  input  logic reset_n,
  input  logic apu_enable,
  input  logic div_bit,
  output logic tick
);

`ifdef GB_APU_FS_DIV_EDGE_EN

  // History always follows div_bit, so a level already low at enable is not an edge.
  logic div_q;

  // Capture previous div_bit level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_bit;
    end
  end

  assign tick = apu_enable & div_q & ~div_bit;

`else

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;
  logic          unused_div;

  assign unused_div = div_bit;
  assign at_last    = (cnt_q == CNT_LAST);
  assign tick       = apu_enable & at_last;

  // Counter held at zero while powered off, wraps after the last count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!apu_enable || at_last) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`endif

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// Game Boy APU 512 Hz frame sequencer: step counter and registered strobes.
// Build option GB_APU_FS_DIV_EDGE_EN selects the DIV-edge tick source
// (default: internal prescaler of PRESCALE clk cycles).
module gb_apu_frame_sequencer
  import gb_apu_pkg::*;
#(
  parameter int PRESCALE = FS_PRESCALE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       apu_enable,
  input  logic       div_bit,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] step,
  output logic       length_skip
);

  logic        tick;
  fs_step_t    step_q;
  fs_step_t    step_d;
  fs_strobes_t strobes_q;
  fs_strobes_t strobes_d;

  gb_apu_fs_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .apu_enable (apu_enable),
    .div_bit    (div_bit),
    .tick       (tick)
  );

  // Execute the current step on a tick; power-off overrides any tick.
  always_comb begin
    step_d    = step_q;
    strobes_d = '0;
    if (!apu_enable) begin
      step_d = '0;
    end else if (tick) begin
      strobes_d = fs_schedule(step_q);
      step_d    = (step_q == fs_step_t'(FS_STEPS - 1)) ? '0 : step_q + 1'b1;
    end
  end

  // Step counter and one-cycle strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q    <= '0;
      strobes_q <= '0;
    end else begin
      step_q    <= step_d;
      strobes_q <= strobes_d;
    end
  end

  assign step           = step_q;
  assign clk_length_ctr = strobes_q.length;
  assign clk_sweep      = strobes_q.sweep;
  assign clk_envelope   = strobes_q.envelope;
  assign length_skip    = step_q[0];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Directed bench for gb_apu_frame_sequencer (PRESCALE=4 in prescaler mode,
// DIV falling-edge stimulus when GB_APU_FS_DIV_EDGE_EN is defined).
module tb_gb_apu_frame_sequencer;

  logic       clk;
  logic       reset_n;
  logic       apu_enable;
  logic       div_bit;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_envelope;
  logic [2:0] step;
  logic       length_skip;

  int checks;
  int errors;
  int model_step;

  gb_apu_frame_sequencer #(
    .PRESCALE (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .apu_enable     (apu_enable),
    .div_bit        (div_bit),
    .clk_length_ctr (clk_length_ctr),
    .clk_sweep      (clk_sweep),
    .clk_envelope   (clk_envelope),
    .step           (step),
    .length_skip    (length_skip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hand-written schedule: {envelope, sweep, length}.
  function automatic logic [2:0] exp_strobes(input int s);
    case (s)
      0: return 3'b001;
      2: return 3'b011;
      4: return 3'b001;
      6: return 3'b011;
      7: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Compare every output against an expected step and strobe set.
  task automatic check_all(input string tag, input int exp_step, input logic [2:0] exp_str);
    logic [2:0] e;
    e = exp_str;
    check({tag, "_step"}, int'(step), exp_step);
    check({tag, "_len"}, int'(clk_length_ctr), int'(e[0]));
    check({tag, "_swp"}, int'(clk_sweep), int'(e[1]));
    check({tag, "_env"}, int'(clk_envelope), int'(e[2]));
    check({tag, "_skip"}, int'(length_skip), exp_step % 2);
    $display("t=%0t %s step=%0d len=%0b swp=%0b env=%0b skip=%0b",
             $time, tag, step, clk_length_ctr, clk_sweep, clk_envelope, length_skip);
  endtask

`ifndef GB_APU_FS_DIV_EDGE_EN
  // Prescaler of 4 starting from count 0: three quiet cycles, strobe on the fourth.
  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) begin
          check_all("quiet", model_step, 3'b000);
        end else begin
          check_all("tick", (model_step + 1) % 8, exp_strobes(model_step));
          model_step = (model_step + 1) % 8;
        end
      end
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    model_step = 0;
    reset_n    = 1'b0;
    apu_enable = 1'b0;
    div_bit    = 1'b0;

    #1;
    check_all("reset", 0, 3'b000);
    @(negedge clk);
    check_all("reset_clk", 0, 3'b000);

`ifndef GB_APU_FS_DIV_EDGE_EN
    // Full cycle of eight steps, wrap to 0.
    reset_n    = 1'b1;
    apu_enable = 1'b1;
    model_step = 0;
    run_ticks(8);
    check("wrap", int'(step), 0);

    // Advance to step 3 then power off.
    run_ticks(3);
    apu_enable = 1'b0;
    @(negedge clk);
    check_all("disable", 0, 3'b000);
    @(negedge clk);
    check_all("disable_hold", 0, 3'b000);

    // Re-enable: first tick is step 0 (length).
    apu_enable = 1'b1;
    model_step = 0;
    run_ticks(1);

    // Tick pending in the same cycle enable drops.
    @(negedge clk);
    check_all("pre_drop1", 1, 3'b000);
    @(negedge clk);
    check_all("pre_drop2", 1, 3'b000);
    @(negedge clk);
    check_all("pre_drop3", 1, 3'b000);
    apu_enable = 1'b0;
    @(negedge clk);
    check_all("tick_disable", 0, 3'b000);

    // Run to step 5 with a tick pending, then asynchronous reset.
    apu_enable = 1'b1;
    model_step = 0;
    run_ticks(5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_all("pre_reset", 5, 3'b000);
    #2 reset_n = 1'b0;
    #1;
    check_all("async_reset", 0, 3'b000);
    @(negedge clk);
    check_all("reset_hold", 0, 3'b000);
    reset_n    = 1'b1;
    model_step = 0;
    run_ticks(2);
`else
    // History follows div_bit while off: low level at enable gives no tick.
    reset_n = 1'b1;
    div_bit = 1'b1;
    @(negedge clk);
    div_bit = 1'b0;
    @(negedge clk);
    apu_enable = 1'b1;
    @(negedge clk);
    check_all("edge_low_at_en", 0, 3'b000);
    @(negedge clk);
    check_all("edge_low_at_en2", 0, 3'b000);

    // Eight 1,0 toggles: strobe one cycle after each fall, none on rises.
    for (int i = 0; i < 8; i++) begin
      div_bit = 1'b1;
      @(negedge clk);
      check_all("edge_rise", i, 3'b000);
      div_bit = 1'b0;
      @(negedge clk);
      check_all("edge_fall", (i + 1) % 8, exp_strobes(i));
    end

    // Falling edge in the same cycle enable drops.
    div_bit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    div_bit    = 1'b0;
    apu_enable = 1'b0;
    @(negedge clk);
    check_all("edge_tick_disable", 0, 3'b000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
